display_mux_bcd: RTL and testbench
==================================

// Module: display_mux_bcd
// PURPOSE
//   Multiplexed N-digit 7-segment driver with a built-in sequential binary-to-BCD
//   converter (double dabble, one shift per clk). It latches a binary value on
//   request, converts it, and shows the decimal result on a time-multiplexed display.
//   It also provides leading-zero blanking, per-digit decimal points and overflow
//   indication. It sits between datapath counters/registers and the board PMOD/display pins.
// PARAMETERS
//   NDIGITS      4   number of displayed decimal digits (1..8)
//   NBITS        14  width of binary input (1..27)
//   SCAN_DIV     16  digit dwell = 2**SCAN_DIV clk cycles
//   SEG_ACT_LOW  1   1: segments driven active-low; 0: active-high
//   BLANK_LZ     1   1: leading-zero blanking enabled
// PORTS
//   clk       in   1          system clock, all logic on rising edge
//   rst       in   1          synchronous, active-high reset
//   bin_in    in   NBITS      unsigned binary value, sampled when load accepted
//   dp_in     in   NDIGITS    decimal point per digit, bit0 = least-significant digit
//   load      in   1          request conversion; accepted only when busy==0
//   busy      out  1          conversion in progress
//   done      out  1          1-cycle pulse when new value is committed to display
//   catodes   out  NDIGITS    one-hot digit enable, active-high, bit0 = LSD
//   segments  out  8          {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
// BEHAVIOUR
// - Reset (sync): busy=0, done=0, FSM=IDLE, prescaler=0, digit index=0, catodes=1,
//   display BCD=0, overflow=0. Segments show "0" on digit 0 with dp from dp_in[0].
// - Converter FSM, IDLE -> SHIFT -> COMMIT -> IDLE:
//   * IDLE: load=1 captures bin_in, clears scratch BCD, busy<=1, goes to SHIFT.
//   * SHIFT: exactly NBITS cycles. Each cycle adds 3 to every nibble >=5,
//     then shifts left 1, MSB of shift reg entering BCD bit0.
//   * COMMIT: 1 cycle. Display BCD<=scratch, overflow<=any bit shifted out
//     above nibble NDIGITS-1 (value > 10**NDIGITS-1), done=1, busy<=0.
// - Latency: load sampled at edge T -> busy=1 from T; done=1 and new digits
//   visible in cycle T+NBITS+1; next load is accepted at T+NBITS+2.
// - load while busy is ignored (no queue); bin_in changes during conversion
//   have no effect. Display BCD changes only at COMMIT, so there is no tearing.
// - Scan: free-running SCAN_DIV-bit prescaler. On wrap, digit index increments
//   and wraps NDIGITS-1 -> 0. catodes = 1<<index, always exactly one hot.
// - Digit decode, standard 0-9: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D,
//   7=07, 8=7F, 9=6F (active-high a..g). Nibbles >9 cannot occur; decode them
//   as blank.
// - Blanking (BLANK_LZ=1): digit i>0 is blank if it and all higher digits are 0.
//   Digit 0 is never blanked. The dp bit is never blanked.
// - Overflow=1: every digit shows only g ("-"), and dp is still from dp_in.
// - Output polarity: if SEG_ACT_LOW, segments = ~active_high_pattern.
// - segments/catodes are registered and update together; 1 cycle behind index.
// - rst mid-conversion aborts it; display returns to the reset state.
// TESTING
//   1 Reset: rst 2 cycles -> catodes=0001, segments=~8'h3F, busy=0, done=0.
//   2 bin_in=1234, load 1 cycle -> busy=1 for 15 cycles, done pulse at T+15,
//     digits scan 4,3,2,1 -> LSD first: ~66,~4F,~5B,~06.
//   3 bin_in=7, BLANK_LZ=1 -> digits 1..3 segments=8'hFF, digit0=~07. Then
//     bin_in=0 -> digit0 shows "0".
//   4 bin_in=12000 (NDIGITS=4) -> overflow; all digits ~8'h40. Next load of 9999
//     clears it.
//   5 load held high continuously -> back-to-back conversions, one every 16
//     cycles. A load pulse mid-conversion is ignored; the bin_in change is not seen.
//   6 rst asserted at SHIFT cycle 5 -> next cycle busy=0, display "0", catodes=0001.

Source files
------------

// File: rtl/display_mux_bcd.sv
// Multiplexed N-digit 7-segment driver with a sequential double-dabble converter.
// A loaded binary value is converted one bit per clock and committed atomically to the display.
module display_mux_bcd #(
    parameter int NDIGITS     = 4,
    parameter int NBITS       = 14,
    parameter int SCAN_DIV    = 16,
    parameter int SEG_ACT_LOW = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NBITS-1:0]   bin_in,
    input  logic [NDIGITS-1:0] dp_in,
    input  logic               load,
    output logic               busy,
    output logic               done,
    output logic [NDIGITS-1:0] catodes,
    output logic [7:0]         segments
);
    localparam int BW = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q;
    logic [NBITS-1:0]   sh_q;
    logic [BW-1:0]      scr_q, scr_d;
    logic               scr_ovf_q;
    logic [CW-1:0]      cnt_q;
    logic [BW-1:0]      disp_q;
    logic               ovf_q;
    logic               busy_q, done_q;

    logic [SCAN_DIV-1:0] presc_q;
    logic [IW-1:0]       idx_q;
    logic [NDIGITS-1:0]  cat_q;
    logic [7:0]          seg_q, seg_d;
    logic [NDIGITS-1:0]  blank;
    logic                lz_run;
    logic [3:0]          nib;
    logic                cur_blank, cur_dp;
    logic [6:0]          pat;

    function automatic logic [7:0] drive(input logic [7:0] p);
        return (SEG_ACT_LOW != 0) ? ~p : p;
    endfunction

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        scr_d = scr_q;
        for (int i = 0; i < NDIGITS; i++)
            if (scr_q[4*i +: 4] >= 4'd5) scr_d[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            scr_q     <= '0;
            scr_ovf_q <= 1'b0;
            cnt_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (load) begin
                    sh_q      <= bin_in;
                    scr_q     <= '0;
                    scr_ovf_q <= 1'b0;
                    cnt_q     <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    // A bit leaving the top nibble means the value needs more digits.
                    scr_q     <= {scr_d[BW-2:0], sh_q[NBITS-1]};
                    scr_ovf_q <= scr_ovf_q | scr_d[BW-1];
                    sh_q      <= sh_q << 1;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NBITS - 1)) state_q <= COMMIT;
                end
                COMMIT: begin
                    disp_q  <= scr_q;
                    ovf_q   <= scr_ovf_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Digit i>0 is blank when it and every higher digit are zero.
    always_comb begin
        lz_run = 1'b1;
        blank  = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            lz_run   = lz_run & (disp_q[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i > 0) && lz_run;
        end
    end

    always_comb begin
        nib       = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < NDIGITS; i++)
            if (idx_q == IW'(i)) begin
                nib       = disp_q[4*i +: 4];
                cur_blank = blank[i];
                cur_dp    = dp_in[i];
            end
        case (nib)
            4'd0: pat = 7'h3F;
            4'd1: pat = 7'h06;
            4'd2: pat = 7'h5B;
            4'd3: pat = 7'h4F;
            4'd4: pat = 7'h66;
            4'd5: pat = 7'h6D;
            4'd6: pat = 7'h7D;
            4'd7: pat = 7'h07;
            4'd8: pat = 7'h7F;
            4'd9: pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        if (cur_blank) pat = 7'h00;
        if (ovf_q)     pat = 7'h40;
        seg_d = drive({cur_dp, pat});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            cat_q   <= NDIGITS'(1);
            seg_q   <= drive({dp_in[0], 7'h3F});
        end else begin
            presc_q <= presc_q + 1'b1;
            if (presc_q == '1) idx_q <= (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
            cat_q <= NDIGITS'(1) << idx_q;
            seg_q <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign catodes  = cat_q;
    assign segments = seg_q;
endmodule

// File: tb/tb_display_mux_bcd.sv
// Directed bench for display_mux_bcd: timing, decode, blanking, overflow, back-to-back, abort.
// Scan divider is shortened so a full display sweep takes a handful of cycles.
module tb_display_mux_bcd;
    logic        clk, rst, load, busy, done;
    logic [13:0] bin_in;
    logic [3:0]  dp_in, catodes;
    logic [7:0]  segments;
    int nvec = 0, nerr = 0;

    display_mux_bcd #(.NDIGITS(4), .NBITS(14), .SCAN_DIV(2), .SEG_ACT_LOW(1), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .dp_in(dp_in), .load(load),
        .busy(busy), .done(done), .catodes(catodes), .segments(segments)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until digit d is enabled and return its segment pattern.
    task automatic read_digit(input int d, output logic [7:0] seg, output bit ok);
        ok  = 1'b0;
        seg = 8'hxx;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            if (catodes == (4'b0001 << d)) begin seg = segments; ok = 1'b1; break; end
        end
    endtask

    // Pulse load with value v, wait (bounded) for done.
    task automatic run_conv(input logic [13:0] v, output bit got_done);
        @(posedge clk); #1; bin_in = v; load = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin got_done = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; bin_in = '0; dp_in = '0;
        repeat (2) @(posedge clk); #1;
        nvec++; if (catodes !== 4'b0001) begin nerr++; $display("FAIL reset_catodes got %b expected 0001", catodes); end
        nvec++; if (segments !== 8'hC0) begin nerr++; $display("FAIL reset_segments got %h expected c0", segments); end
        nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done); end
        rst = 1'b0;
    endtask

    task automatic test_convert_timing;
        int busy_n, done_at, done_n;
        logic [7:0] s; bit ok;
        logic [7:0] exp_s [4];
        exp_s = '{8'h99, 8'hB0, 8'h24, 8'hF9};
        dp_in = 4'b0100;
        @(posedge clk); #1; bin_in = 14'd1234; load = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        busy_n = 0; done_at = -1; done_n = 0;
        for (int k = 0; k < 21; k++) begin
            if (busy) busy_n++;
            if (done) begin done_n++; if (done_at < 0) done_at = k; end
            @(posedge clk); #1;
        end
        nvec++; if (busy_n != 15) begin nerr++; $display("FAIL conv_busy_cycles got %0d expected 15", busy_n); end
        nvec++; if (done_at != 15) begin nerr++; $display("FAIL conv_done_cycle got %0d expected 15", done_at); end
        nvec++; if (done_n != 1) begin nerr++; $display("FAIL conv_done_pulses got %0d expected 1", done_n); end
        for (int d = 0; d < 4; d++) begin
            read_digit(d, s, ok); nvec++;
            if (!ok || s !== exp_s[d]) begin nerr++; $display("FAIL conv1234_digit%0d got %h expected %h", d, s, exp_s[d]); end
        end
    endtask

    task automatic test_blanking;
        logic [7:0] s; bit ok, got;
        logic [7:0] exp_s [4];
        dp_in = 4'b1000;
        run_conv(14'd7, got);
        nvec++; if (!got) begin nerr++; $display("FAIL blank7_done got timeout expected done"); end
        exp_s = '{8'hF8, 8'hFF, 8'hFF, 8'h7F};
        for (int d = 0; d < 4; d++) begin
            read_digit(d, s, ok); nvec++;
            if (!ok || s !== exp_s[d]) begin nerr++; $display("FAIL blank7_digit%0d got %h expected %h", d, s, exp_s[d]); end
        end
        dp_in = 4'b0000;
        run_conv(14'd0, got);
        nvec++; if (!got) begin nerr++; $display("FAIL blank0_done got timeout expected done"); end
        exp_s = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 4; d++) begin
            read_digit(d, s, ok); nvec++;
            if (!ok || s !== exp_s[d]) begin nerr++; $display("FAIL blank0_digit%0d got %h expected %h", d, s, exp_s[d]); end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] s; bit ok, got;
        logic [7:0] exp_s [4];
        logic [13:0] vals [3];
        logic [3:0]  dps [3];
        logic [7:0]  exps [3][4];
        vals = '{14'd12000, 14'd9999, 14'd10000};
        dps  = '{4'b0001, 4'b0000, 4'b0000};
        exps = '{'{8'h3F, 8'hBF, 8'hBF, 8'hBF},
                 '{8'h90, 8'h90, 8'h90, 8'h90},
                 '{8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        for (int v = 0; v < 3; v++) begin
            dp_in = dps[v];
            run_conv(vals[v], got);
            nvec++; if (!got) begin nerr++; $display("FAIL ovf%0d_done got timeout expected done", vals[v]); end
            exp_s = exps[v];
            for (int d = 0; d < 4; d++) begin
                read_digit(d, s, ok); nvec++;
                if (!ok || s !== exp_s[d]) begin nerr++; $display("FAIL ovf%0d_digit%0d got %h expected %h", vals[v], d, s, exp_s[d]); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2;
        logic [7:0] s; bit ok;
        logic [7:0] exp_s [4];
        exp_s = '{8'h80, 8'hF8, 8'h82, 8'h92};
        dp_in = 4'b0000;
        @(posedge clk); #1; bin_in = 14'd42; load = 1'b1;
        d1 = -1; d2 = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (k == 0) bin_in = 14'd5678;
            if (done) begin
                if (d1 < 0) d1 = k;
                else begin d2 = k; break; end
            end
        end
        load = 1'b0;
        nvec++; if (d1 < 0 || d2 - d1 != 16) begin nerr++; $display("FAIL b2b_spacing got %0d expected 16", d2 - d1); end
        for (int d = 0; d < 4; d++) begin
            read_digit(d, s, ok); nvec++;
            if (!ok || s !== exp_s[d]) begin nerr++; $display("FAIL b2b5678_digit%0d got %h expected %h", d, s, exp_s[d]); end
        end
    endtask

    task automatic test_ignore_load;
        int done_n, busy_n;
        bit got;
        logic [7:0] s; bit ok;
        logic [7:0] exp_s [4];
        exp_s = '{8'h92, 8'hC0, 8'hB0, 8'hFF};
        @(posedge clk); #1; bin_in = 14'd305; load = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        repeat (5) @(posedge clk); #1;
        bin_in = 14'd9999; load = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        nvec++; if (!got) begin nerr++; $display("FAIL ign_done got timeout expected done"); end
        done_n = 0; busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) done_n++;
            if (busy) busy_n++;
        end
        nvec++; if (done_n != 0 || busy_n != 0) begin nerr++; $display("FAIL ign_extra_conv got done=%0d busy=%0d expected 0 0", done_n, busy_n); end
        for (int d = 0; d < 4; d++) begin
            read_digit(d, s, ok); nvec++;
            if (!ok || s !== exp_s[d]) begin nerr++; $display("FAIL ign305_digit%0d got %h expected %h", d, s, exp_s[d]); end
        end
    endtask

    task automatic test_reset_mid;
        int done_n;
        logic [7:0] s; bit ok;
        @(posedge clk); #1; bin_in = 14'd1234; load = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL abort_flags busy=%b done=%b expected 0 0", busy, done); end
        nvec++; if (catodes !== 4'b0001) begin nerr++; $display("FAIL abort_catodes got %b expected 0001", catodes); end
        nvec++; if (segments !== 8'hC0) begin nerr++; $display("FAIL abort_segments got %h expected c0", segments); end
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) done_n++;
        end
        nvec++; if (done_n != 0) begin nerr++; $display("FAIL abort_no_done got %0d expected 0", done_n); end
        read_digit(1, s, ok); nvec++;
        if (!ok || s !== 8'hFF) begin nerr++; $display("FAIL abort_digit1 got %h expected ff", s); end
        read_digit(0, s, ok); nvec++;
        if (!ok || s !== 8'hC0) begin nerr++; $display("FAIL abort_digit0 got %h expected c0", s); end
    endtask

    initial begin
        test_reset;
        test_convert_timing;
        test_blanking;
        test_overflow;
        test_back_to_back;
        test_ignore_load;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
